// File: rtl/ps2_key_event_ctrl.sv
// Folds PS/2 scan-code bytes into key events queued for the CPU, tracking modifiers and status.
// Optional PS2_TYPEMATIC_FILTER_EN: drop repeated makes of the most recently pressed key.
module ps2_key_event_ctrl #(
  parameter int unsigned EVQ_DEPTH   = 8,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic [7:0]                   kb_data,
  input  logic                         kb_ready,
  output logic                         kb_rdn,
  output logic [7:0]                   evt_code,
  output logic                         evt_ext,
  output logic                         evt_brk,
  output logic                         evt_valid,
  input  logic                         evt_rd,
  output logic [$clog2(EVQ_DEPTH):0]   evq_count,
  output logic [5:0]                   mods,
  output logic                         caps,
  output logic [2:0]                   status,
  input  logic                         status_clr
);

  localparam int unsigned PW = $clog2(EVQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  typedef enum logic [1:0] {S_WAIT, S_PROC, S_SKIP} state_t;

  state_t        state;
  logic [7:0]    byte_r;
  logic          ext_p, brk_p;
  logic [2:0]    skip;
  logic [TW-1:0] timer;
  logic          caps_held;
  logic          st_tmo, st_err, st_bat;

  evt_t          mem [EVQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic full, rd_ok, pop, push, is_evt, special, drop, pause_push, running, tmo;
  evt_t push_data, head;

  // Byte classification and queue/timer control
  always_comb begin
    special = 1'b0;
    unique case (byte_r)
      8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: special = 1'b1;
      default: special = 1'b0;
    endcase
    full       = (count == CW'(EVQ_DEPTH));
    // A pop strobe in flight means the receiver head is still the byte just taken
    rd_ok      = kb_ready && !kb_rdn && !full;
    pop        = evt_rd && evt_valid;
    is_evt     = (state == S_PROC) && !special;
    pause_push = (state == S_SKIP) && rd_ok && (skip == 3'd1);
    running    = ((state == S_WAIT) && (ext_p || brk_p)) || (state == S_SKIP);
    tmo        = running && !rd_ok && (timer == TW'(TIMEOUT_CYC - 1));
    push       = (is_evt && !drop) || pause_push;
    push_data  = pause_push ? evt_t'{brk: 1'b0, ext: 1'b1, code: 8'hE1}
                            : evt_t'{brk: brk_p, ext: ext_p, code: byte_r};
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       lm_valid;
  logic [8:0] last_make;

  assign drop = is_evt && !brk_p && lm_valid && (last_make == {ext_p, byte_r});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lm_valid  <= 1'b0;
      last_make <= '0;
    end else if (is_evt) begin
      if (!brk_p) begin
        lm_valid  <= 1'b1;
        last_make <= {ext_p, byte_r};
      end else if (lm_valid && (last_make == {ext_p, byte_r})) begin
        lm_valid <= 1'b0;
      end
    end
  end
`else
  assign drop = 1'b0;
`endif

  // Event queue storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;
  assign evt_valid = (count != '0);
  assign evq_count = count;
  assign status    = {st_tmo, st_err, st_bat};

  // Event queue pointers and occupancy
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status; a same-cycle set overrides the clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st_tmo <= 1'b0;
      st_err <= 1'b0;
      st_bat <= 1'b0;
    end else begin
      st_tmo <= tmo | (st_tmo & ~status_clr);
      st_err <= ((state == S_PROC) && ((byte_r == 8'h00) || (byte_r == 8'hFF))) | (st_err & ~status_clr);
      st_bat <= ((state == S_PROC) && (byte_r == 8'hAA)) | (st_bat & ~status_clr);
    end
  end

  // Modifier and caps-lock tracking on pushed key events
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mods      <= '0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
    end else if (is_evt && !drop) begin
      case ({ext_p, byte_r})
        9'h012:  mods[0] <= !brk_p;
        9'h059:  mods[1] <= !brk_p;
        9'h014:  mods[2] <= !brk_p;
        9'h114:  mods[3] <= !brk_p;
        9'h011:  mods[4] <= !brk_p;
        9'h111:  mods[5] <= !brk_p;
        default: ;
      endcase
      if (!ext_p && (byte_r == 8'h58)) begin
        if (!brk_p) begin
          if (!caps_held) caps <= ~caps;
          caps_held <= 1'b1;
        end else begin
          caps_held <= 1'b0;
        end
      end
    end
  end

  // Receiver handshake and prefix sequencing
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= S_WAIT;
      kb_rdn <= 1'b0;
      byte_r <= '0;
      ext_p  <= 1'b0;
      brk_p  <= 1'b0;
      skip   <= '0;
      timer  <= '0;
    end else begin
      kb_rdn <= 1'b0;
      case (state)
        S_WAIT: begin
          if (rd_ok) begin
            kb_rdn <= 1'b1;
            byte_r <= kb_data;
            timer  <= '0;
            state  <= S_PROC;
          end else if (tmo) begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            timer <= '0;
          end else if (running) begin
            timer <= timer + TW'(1);
          end else begin
            timer <= '0;
          end
        end
        S_PROC: begin
          state <= S_WAIT;
          case (byte_r)
            8'hE0: ext_p <= 1'b1;
            8'hF0: brk_p <= 1'b1;
            8'hE1: begin
              skip  <= 3'd7;
              state <= S_SKIP;
            end
            default: begin
              ext_p <= 1'b0;
              brk_p <= 1'b0;
            end
          endcase
        end
        S_SKIP: begin
          if (rd_ok) begin
            kb_rdn <= 1'b1;
            timer  <= '0;
            skip   <= skip - 3'd1;
            if (skip == 3'd1) state <= S_WAIT;
          end else if (tmo) begin
            skip  <= '0;
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            timer <= '0;
            state <= S_WAIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench for ps2_key_event_ctrl: directed scenarios plus random byte streams vs a byte-stream model.
module tb_ps2_key_event_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 300;

  logic                       clk = 1'b0;
  logic                       clrn = 1'b0;
  logic [7:0]                 kb_data = '0;
  logic                       kb_ready = 1'b0;
  logic                       kb_rdn;
  logic [7:0]                 evt_code;
  logic                       evt_ext, evt_brk, evt_valid;
  logic                       evt_rd = 1'b0;
  logic [$clog2(DEPTH):0]     evq_count;
  logic [5:0]                 mods;
  logic                       caps;
  logic [2:0]                 status;
  logic                       status_clr = 1'b0;

  ps2_key_event_ctrl #(.EVQ_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready), .kb_rdn(kb_rdn),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_valid(evt_valid),
    .evt_rd(evt_rd), .evq_count(evq_count), .mods(mods), .caps(caps), .status(status),
    .status_clr(status_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int rdn_cnt = 0, rdn_double = 0, rdn_empty = 0, rd_prob = 0;
  bit rdn_prev = 1'b0, rd_once = 1'b0;
  logic [7:0] rx_q [$];
  logic [9:0] got_q [$];
  logic [9:0] exp_q [$];

  // Reference model state: follows the byte stream, not the DUT's timing
  int         m_skip;
  bit         m_ext, m_brk, m_caps, m_caps_held, lm_v;
  logic [5:0] m_mods;
  logic [2:0] m_status;
  logic [8:0] lm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_skip = 0; m_ext = 0; m_brk = 0; m_caps = 0; m_caps_held = 0; lm_v = 0;
    m_mods = '0; m_status = '0; lm = '0;
  endtask

  task automatic model_key(input bit brk, input bit ext, input logic [7:0] code);
    int idx;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (!brk) begin
      if (lm_v && lm == {ext, code}) return;
      lm = {ext, code}; lm_v = 1;
    end else if (lm_v && lm == {ext, code}) begin
      lm_v = 0;
    end
`endif
    exp_q.push_back({brk, ext, code});
    case ({ext, code})
      9'h012: idx = 0;
      9'h059: idx = 1;
      9'h014: idx = 2;
      9'h114: idx = 3;
      9'h011: idx = 4;
      9'h111: idx = 5;
      default: idx = -1;
    endcase
    if (idx >= 0) m_mods[idx] = !brk;
    if (!ext && code == 8'h58) begin
      if (!brk) begin
        if (!m_caps_held) m_caps = !m_caps;
        m_caps_held = 1;
      end else m_caps_held = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) exp_q.push_back(10'h1E1);
      return;
    end
    case (b)
      8'hE0: m_ext = 1;
      8'hF0: m_brk = 1;
      8'hE1: m_skip = 7;
      8'hAA: begin m_status[0] = 1; m_ext = 0; m_brk = 0; end
      8'hFA, 8'hEE, 8'hFE, 8'hFC: begin m_ext = 0; m_brk = 0; end
      8'h00, 8'hFF: begin m_status[1] = 1; m_ext = 0; m_brk = 0; end
      default: begin model_key(m_brk, m_ext, b); m_ext = 0; m_brk = 0; end
    endcase
  endtask

  task automatic feed(input logic [7:0] b);
    rx_q.push_back(b);
    model_byte(b);
  endtask

  // One clock: receiver FIFO and CPU consumer act on the falling edge
  task automatic tick();
    @(negedge clk);
    if (kb_rdn) begin
      rdn_cnt++;
      if (rdn_prev) rdn_double++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      else rdn_empty++;
    end
    rdn_prev = kb_rdn;
    if (evt_valid && (rd_once || ($urandom_range(0, 99) < rd_prob))) begin
      got_q.push_back({evt_brk, evt_ext, evt_code});
      evt_rd = 1'b1;
    end else evt_rd = 1'b0;
    rd_once  = 1'b0;
    kb_ready = (rx_q.size() > 0);
    kb_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic drain(input int prob);
    int n = 0, idle = 0;
    rd_prob = prob;
    while (idle < 6 && n < 5000) begin
      tick(); n++;
      if (rx_q.size() == 0 && !evt_valid && !kb_rdn) idle++; else idle = 0;
    end
    chk("drain_bound", 32'(n < 5000), 1);
    rd_prob = 0;
  endtask

  task automatic cmp_events(input string tag);
    int n;
    chk({tag, "_evcount"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_mods"}, 32'(mods), 32'(m_mods));
    chk({tag, "_caps"}, 32'(caps), 32'(m_caps));
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, k;
    logic [7:0] codes [6];
    codes = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C};
    m_reset();
    repeat (3) tick();
    chk("rst_kb_rdn", 32'(kb_rdn), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evq_count", 32'(evq_count), 0);
    chk("rst_mods_caps_status", 32'({mods, caps, status}), 0);
    clrn = 1'b1;
    tick();

    // Single make: latency and strobe width
    base = rdn_cnt;
    feed(8'h1C);
    tick();
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (evt_valid) begin k = i; break; end
    end
    chk("lat_evt_valid", k, 2);
    chk("lat_head", 32'({evt_brk, evt_ext, evt_code}), 32'h01C);
    drain(100);
    chk("lat_rdn_pulses", rdn_cnt - base, 1);
    cmp_events("make1c");

    // Right ctrl make then extended break
    feed(8'hE0); feed(8'h14);
    drain(100);
    chk("rctrl_held", 32'(mods[3]), 1);
    cmp_events("rctrl_make");
    feed(8'hE0); feed(8'hF0); feed(8'h14);
    drain(100);
    chk("rctrl_brk_head", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFF, 32'h314);
    chk("rctrl_released", 32'(mods[3]), 0);
    cmp_events("rctrl_brk");

    // Pause sequence
    base = rdn_cnt;
    foreach (codes[i]) ;
    feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1);
    feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77);
    drain(100);
    chk("pause_rdn_pulses", rdn_cnt - base, 8);
    chk("pause_event", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFF, 32'h1E1);
    cmp_events("pause");

    // Caps lock with a typematic repeat
    feed(8'h58); feed(8'h58); feed(8'hF0); feed(8'h58);
    drain(100);
    chk("caps_on", 32'(caps), 1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("caps_evcount", got_q.size(), 2);
`else
    chk("caps_evcount", got_q.size(), 3);
`endif
    cmp_events("caps");

    // Full queue blocks receiver reads
    base = rdn_cnt;
    for (int i = 0; i < int'(DEPTH) + 2; i++) feed(8'(8'h20 + i));
    repeat (30) tick();
    chk("full_count", 32'(evq_count), DEPTH);
    chk("full_reads", rdn_cnt - base, DEPTH);
    chk("full_rx_left", rx_q.size(), 2);
    rd_once = 1'b1;
    repeat (20) tick();
    chk("full_one_more_read", rdn_cnt - base, DEPTH + 1);
    chk("full_count_after", 32'(evq_count), DEPTH);
    drain(100);
    cmp_events("full");

    // Prefix timeout, then recovery, BAT and status clear
    feed(8'hE0);
    repeat (TMO - 10) tick();
    chk("tmo_not_yet", 32'(status[2]), 0);
    repeat (20) tick();
    chk("tmo_set", 32'(status[2]), 1);
    chk("tmo_no_event", 32'(evq_count), 0);
    m_ext = 0; m_status[2] = 1;
    feed(8'h1C);
    drain(100);
    chk("tmo_recover", got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFF, 32'h01C);
    cmp_events("tmo");
    feed(8'hAA);
    drain(100);
    chk("bat_status", 32'(status), 32'(m_status));
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    m_status = '0;
    chk("status_cleared", 32'(status), 0);
    cmp_events("bat");

    // Reset in the middle of a pause sequence
    feed(8'hE1); feed(8'h14); feed(8'hE0);
    repeat (8) tick();
    chk("midrst_no_event", 32'(evq_count), 0);
    clrn = 1'b0;
    rx_q.delete();
    kb_ready = 1'b0;
    tick(); tick();
    clrn = 1'b1;
    rdn_prev = 1'b0;
    m_reset(); exp_q.delete(); got_q.delete();
    chk("midrst_count", 32'(evq_count), 0);
    feed(8'h1C);
    drain(100);
    cmp_events("midrst");

    // Random token stream with a random consumer
    for (int t = 0; t < 150; t++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 9);
      c = ($urandom_range(0, 7) < 6) ? codes[$urandom_range(0, 5)] : 8'($urandom_range(1, 127));
      case (r)
        4: begin feed(8'hF0); feed(c); end
        5: begin feed(8'hE0); feed(c); end
        6: begin feed(8'hE0); feed(8'hF0); feed(c); end
        7: begin feed(8'hE1); for (int j = 0; j < 7; j++) feed(8'($urandom_range(0, 255))); end
        8: begin
          logic [7:0] acks [5];
          acks = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC};
          feed(acks[$urandom_range(0, 4)]);
        end
        9: feed(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
        default: feed(c);
      endcase
    end
    drain(60);
    chk("rand_status", 32'(status), 32'(m_status));
    cmp_events("rand");

    chk("rdn_single_cycle", rdn_double, 0);
    chk("rdn_on_empty", rdn_empty, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequences the PS/2 keyboard receiver through its `ready`/`rdn` pop handshake.
- Folds raw scan-code bytes (E0/F0/E1 prefixes) into single key events and pushes them into a local event queue for the CPU.
- Maintains live modifier/caps-lock state and sticky error status.
- Sits between the PS/2 receiver FIFO and the system bus peripheral interface.

Parameters:
- EVQ_DEPTH, 8: event queue entries; power of 2, minimum 2.
- TIMEOUT_CYC, 2500000: clk cycles a pending prefix may wait for its next byte (50 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- clrn  in  1  asynchronous active-low reset.
- kb_data  in  8  receiver head byte; valid while kb_ready=1.
- kb_ready  in  1  receiver FIFO not empty.
- kb_rdn  out  1  one-cycle active-high pop strobe to the receiver.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event had E0 prefix.
- evt_brk  out  1  head event is a release (F0).
- evt_valid  out  1  event queue not empty.
- evt_rd  in  1  pop head event; ignored when evt_valid=0.
- evq_count  out  $clog2(EVQ_DEPTH)+1  queued events.
- mods  out  6  {ralt,lalt,rctrl,lctrl,rshift,lshift}, 1 = held.
- caps  out  1  caps-lock toggle state.
- status  out  3  sticky {timeout,kb_err,bat_ok}.
- status_clr  in  1  clears the status bits.

Behaviour:
- Reset (clrn=0, async): all of the following are 0 — kb_rdn, evt_valid, evq_count, mods, caps, status, prefixes, queue pointers, skip counter, timer. State = S_WAIT.
- FSM states: S_WAIT, S_PROC, S_SKIP.
- S_WAIT:
  - If kb_ready=1 and queue not full: kb_rdn=1 for this cycle only, latch kb_data into byte_r, go to S_PROC.
  - If the queue is full, do not read; the receiver buffers.
- S_PROC (kb_rdn=0; decide on byte_r, always one cycle):
  - E0: ext_p<=1, go to S_WAIT.
  - F0: brk_p<=1, go to S_WAIT.
  - E1: skip<=7, go to S_SKIP.
  - AA: bat_ok<=1; FA, EE, FE, FC: no effect. Clear prefixes, go to S_WAIT. No event.
  - 00 or FF: kb_err<=1, clear prefixes, go to S_WAIT. No event.
  - Any other byte:
    - Push {brk_p,ext_p,byte_r}, update modifiers, clear prefixes, go to S_WAIT.
    - If the queue became full since the read, the push still occurs: the full check in S_WAIT reserves the slot.
- S_SKIP:
  - Pop bytes as in S_WAIT and decrement skip on each pop.
  - When skip reaches 0, push {brk=0,ext=1,code=8'hE1} (Pause) and go to S_WAIT.
  - The timeout also applies here.
- Latency: byte present at cycle N (S_WAIT) → event pushed at N+1 edge → evt_valid=1 at N+2.
- Modifiers:
  - Codes: lshift 12, rshift 59, lctrl 14, rctrl E0 14, lalt 11, ralt E0 11.
  - Make sets the bit; break clears it.
  - caps toggles on a make of 58 only when caps_held=0; caps_held is set by make 58 and cleared by break 58.
- Timeout:
  - Timer runs while (ext_p|brk_p) in S_WAIT, or while in S_SKIP; it resets on every pop.
  - On reaching TIMEOUT_CYC: clear prefixes and skip, go to S_WAIT, set timeout<=1. No event.
- Event queue:
  - Circular, 10-bit entries; outputs show the head combinationally.
  - Pop on evt_rd & evt_valid.
  - Simultaneous push and pop: count unchanged, both occur.
  - Pointer wrap at EVQ_DEPTH.
  - Never overwrites.
- status_clr clears all status bits. If it coincides with a same-cycle set, the set wins.
- Reset asserted mid-sequence (after E0/F0 or inside S_SKIP) discards the partial sequence with no event.

Optional Feature:
- PS2_TYPEMATIC_FILTER_EN defined:
  - Register last_make {ext,code}, with a valid bit.
  - A make equal to last_make is dropped: no push and no modifier change.
  - Any other make replaces last_make.
  - A break matching last_make invalidates it.
- Undefined: every make, including typematic repeats, is pushed.

Test Plan:
- Feed 1C → one event {brk0,ext0,1C}; evt_valid rises 2 cycles after kb_ready; kb_rdn is exactly 1 cycle wide.
- Feed E0,F0,14 → one event {brk1,ext1,14}; rctrl held beforehand then cleared; no events for the prefixes.
- Feed E1,14,77,E1,F0,14,F0,77 → single event {0,1,E1}; exactly 8 kb_rdn pulses.
- Feed 58,58,F0,58 → caps=1 (not re-toggled by the repeat). With PS2_TYPEMATIC_FILTER_EN: 2 events. Without: 3 events.
- Fill queue (EVQ_DEPTH events, evt_rd=0) while kb_ready=1 → kb_rdn stays 0. One evt_rd → exactly one further byte is read.
- Feed E0 then idle TIMEOUT_CYC cycles → status[2]=1, no event; next byte 1C yields {0,0,1C}. Feed AA → status[0]=1; status_clr clears it.
